// File: rtl/flex_counter_mm_if.sv
// flex_counter_mm_if: control and status bundle for flex_counter_mm.
//   master : drives clear/load/load_val/count_enable/dir/sat_mode/rollover_val,
//            observes count_out/rollover_flag/wrap_pulse.
//   slave  : the counter side of the same signals.
interface flex_counter_mm_if #(
  parameter int NUM_CNT_BITS = 4
);
  logic                    clear;
  logic                    load;
  logic [NUM_CNT_BITS-1:0] load_val;
  logic                    count_enable;
  logic                    dir;
  logic                    sat_mode;
  logic [NUM_CNT_BITS-1:0] rollover_val;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    rollover_flag;
  logic                    wrap_pulse;

  modport master (
    output clear, load, load_val, count_enable, dir, sat_mode, rollover_val,
    input  count_out, rollover_flag, wrap_pulse
  );

  modport slave (
    input  clear, load, load_val, count_enable, dir, sat_mode, rollover_val,
    output count_out, rollover_flag, wrap_pulse
  );
endinterface

// File: rtl/flex_counter_mm.sv
// flex_counter_mm: up/down counter with load, wrap/saturate modes, a level
// terminal flag and a one-cycle wrap pulse. Counts use the 1..rollover_val
// convention; 0 only appears after reset, clear or a load of 0.
//   CLK  : clock, all state on rising edge
//   RST  : asynchronous active-high reset
//   bus  : slave side of flex_counter_mm_if (controls in, count/flags out)
module flex_counter_mm #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic               CLK,
  input  logic               RST,
  flex_counter_mm_if.slave   bus
);
  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] r_cnt;
  logic                    r_flag;
  logic                    r_pulse;

  logic [NUM_CNT_BITS-1:0] w_next;
  logic [NUM_CNT_BITS-1:0] w_term;
  logic                    w_wrap;
  logic                    w_rv_zero;

  // Terminal value follows the current direction so the flag tracks dir
  // changes even while holding.
  assign w_term    = bus.dir ? ONE : bus.rollover_val;
  assign w_rv_zero = (bus.rollover_val == '0);

  always_comb begin
    w_next = r_cnt;
    w_wrap = 1'b0;
    if (bus.clear) begin
      w_next = '0;
    end else if (bus.load) begin
      w_next = bus.load_val;
    end else if (bus.count_enable && !w_rv_zero) begin
      if (!bus.dir) begin
        // >= also catches rollover_val being lowered below the count.
        if (r_cnt < bus.rollover_val) begin
          w_next = NUM_CNT_BITS'(r_cnt + ONE);
        end else if (bus.sat_mode) begin
          w_next = bus.rollover_val;
        end else begin
          w_next = ONE;
          w_wrap = 1'b1;
        end
      end else begin
        // Out-of-range (above limit) and the post-clear 0 both reload
        // without a pulse; only a genuine 1 -> rollover_val step wraps.
        if (r_cnt == '0 || r_cnt > bus.rollover_val) begin
          w_next = bus.rollover_val;
        end else if (r_cnt != ONE) begin
          w_next = r_cnt - ONE;
        end else if (!bus.sat_mode) begin
          w_next = bus.rollover_val;
          w_wrap = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt   <= '0;
      r_flag  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_cnt   <= w_next;
      r_flag  <= (w_next == w_term) && !w_rv_zero;
      r_pulse <= w_wrap;
    end
  end

  assign bus.count_out     = r_cnt;
  assign bus.rollover_flag = r_flag;
  assign bus.wrap_pulse    = r_pulse;
endmodule

// File: tb/tb_flex_counter_mm.sv
module tb_flex_counter_mm;
  localparam int N = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  flex_counter_mm_if #(.NUM_CNT_BITS(N)) bus ();

  flex_counter_mm #(.NUM_CNT_BITS(N)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference state
  int m_cnt   = 0;
  int m_flag  = 0;
  int m_pulse = 0;

  typedef struct {
    bit clr, ld; int lv; bit en, dr, sat; int rv;
    int e_cnt; int e_flag; int e_pulse;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit clr, input bit ld, input int lv, input bit en,
                       input bit dr, input bit sat, input int rv);
    bus.clear        = clr;
    bus.load         = ld;
    bus.load_val     = N'(lv);
    bus.count_enable = en;
    bus.dir          = dr;
    bus.sat_mode     = sat;
    bus.rollover_val = N'(rv);
  endtask

  // Next state straight from the behavioural rules, as plain integers.
  task automatic model_step();
    int c, rv, nxt, p, term;
    c = m_cnt; rv = int'(bus.rollover_val); p = 0;
    if (RST) begin
      m_cnt = 0; m_flag = 0; m_pulse = 0;
      return;
    end
    if (bus.clear) nxt = 0;
    else if (bus.load) nxt = int'(bus.load_val);
    else if (!bus.count_enable || rv == 0) nxt = c;
    else if (!bus.dir) begin
      if (bus.sat_mode) nxt = (c + 1 < rv) ? c + 1 : rv;
      else if (c >= rv) begin nxt = 1; p = 1; end
      else nxt = c + 1;
    end else begin
      if (c == 0 || c > rv) nxt = rv;
      else if (c == 1) begin
        if (bus.sat_mode) nxt = 1;
        else begin nxt = rv; p = 1; end
      end else nxt = c - 1;
    end
    term    = bus.dir ? 1 : rv;
    m_cnt   = nxt;
    m_flag  = (nxt == term && rv != 0) ? 1 : 0;
    m_pulse = p;
  endtask

  // One edge: advance model, then compare all outputs a little after the edge.
  task automatic tick(input string nm);
    @(posedge CLK);
    model_step();
    #1;
    chk({nm, ".cnt"},   int'(bus.count_out),     m_cnt);
    chk({nm, ".flag"},  int'(bus.rollover_flag), m_flag);
    chk({nm, ".pulse"}, int'(bus.wrap_pulse),    m_pulse);
  endtask

  vec_t tbl[$];

  initial begin
    drive(0, 0, 0, 0, 0, 0, 3);
    #1;
    chk("reset.cnt",   int'(bus.count_out),     0);
    chk("reset.flag",  int'(bus.rollover_flag), 0);
    chk("reset.pulse", int'(bus.wrap_pulse),    0);
    repeat (2) tick("reset_hold");
    @(negedge CLK); RST = 1'b0;

    // {clr,ld,lv,en,dir,sat,rv, cnt,flag,pulse}
    // up wrap, rv=3
    tbl.push_back('{0,0,0,1,0,0,3, 1,0,0});
    tbl.push_back('{0,0,0,1,0,0,3, 2,0,0});
    tbl.push_back('{0,0,0,1,0,0,3, 3,1,0});
    tbl.push_back('{0,0,0,1,0,0,3, 1,0,1});
    tbl.push_back('{0,0,0,0,0,0,3, 1,0,0});
    // priority: clear beats load and enable; then load alone
    tbl.push_back('{1,1,7,1,0,0,3, 0,0,0});
    tbl.push_back('{0,1,7,0,0,0,7, 7,1,0});
    // down wrap, rv=5, from 0
    tbl.push_back('{1,0,0,0,1,0,5, 0,0,0});
    tbl.push_back('{0,0,0,1,1,0,5, 5,0,0});
    tbl.push_back('{0,0,0,1,1,0,5, 4,0,0});
    tbl.push_back('{0,0,0,1,1,0,5, 3,0,0});
    tbl.push_back('{0,0,0,1,1,0,5, 2,0,0});
    tbl.push_back('{0,0,0,1,1,0,5, 1,1,0});
    tbl.push_back('{0,0,0,1,1,0,5, 5,0,1});
    // down saturate
    tbl.push_back('{1,0,0,0,1,1,5, 0,0,0});
    tbl.push_back('{0,0,0,1,1,1,5, 5,0,0});
    tbl.push_back('{0,0,0,1,1,1,5, 4,0,0});
    tbl.push_back('{0,0,0,1,1,1,5, 3,0,0});
    tbl.push_back('{0,0,0,1,1,1,5, 2,0,0});
    tbl.push_back('{0,0,0,1,1,1,5, 1,1,0});
    tbl.push_back('{0,0,0,1,1,1,5, 1,1,0});
    tbl.push_back('{0,0,0,1,1,1,5, 1,1,0});
    // rollover_val=1 wrap: pulse every cycle
    tbl.push_back('{0,0,0,1,0,0,1, 1,1,1});
    tbl.push_back('{0,0,0,1,0,0,1, 1,1,1});

    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].dr, tbl[i].sat, tbl[i].rv);
      @(posedge CLK);
      model_step();
      #1;
      chk($sformatf("vec%0d.cnt", i),   int'(bus.count_out),     tbl[i].e_cnt);
      chk($sformatf("vec%0d.flag", i),  int'(bus.rollover_flag), tbl[i].e_flag);
      chk($sformatf("vec%0d.pulse", i), int'(bus.wrap_pulse),    tbl[i].e_pulse);
    end

    // async reset mid-count
    drive(1, 0, 0, 0, 0, 0, 10); tick("pre_rst_clr");
    drive(0, 0, 0, 1, 0, 0, 10); repeat (3) tick("pre_rst");
    chk("pre_rst.cnt3", int'(bus.count_out), 3);
    #2; RST = 1'b1; #1;
    model_step();
    chk("async_rst.cnt",   int'(bus.count_out),     0);
    chk("async_rst.flag",  int'(bus.rollover_flag), 0);
    chk("async_rst.pulse", int'(bus.wrap_pulse),    0);
    repeat (2) tick("rst_held");
    @(negedge CLK); RST = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 10); tick("rst_release");
    chk("rst_release.cnt0", int'(bus.count_out), 0);

    // up saturate, then lower the limit, then switch to wrap
    drive(0, 0, 0, 1, 0, 1, 10); repeat (10) tick("usat");
    chk("usat.at10", int'(bus.count_out), 10);
    chk("usat.flag", int'(bus.rollover_flag), 1);
    tick("usat_hold");
    chk("usat.hold10", int'(bus.count_out), 10);
    drive(0, 0, 0, 1, 0, 1, 6); tick("usat_lower");
    chk("usat.lower6", int'(bus.count_out), 6);
    chk("usat.lowerflag", int'(bus.rollover_flag), 1);
    drive(0, 0, 0, 1, 0, 0, 6); tick("usat_towrap");
    chk("usat.wrap1", int'(bus.count_out), 1);
    chk("usat.wrappulse", int'(bus.wrap_pulse), 1);

    // toggled enable, then rollover_val=0 disables
    drive(1, 0, 0, 0, 0, 0, 10); tick("tog_clr");
    for (int i = 0; i < 14; i++) begin
      drive(0, 0, 0, (i % 2 == 0), 0, 0, 10); tick("toggle");
    end
    chk("toggle.cnt7", int'(bus.count_out), 7);
    drive(0, 0, 0, 1, 0, 0, 0); tick("rv0");
    chk("rv0.hold", int'(bus.count_out), 7);
    chk("rv0.flag", int'(bus.rollover_flag), 0);

    // direction change with hold: flag recomputes against new terminal
    drive(0, 1, 1, 0, 0, 0, 9); tick("ld1");
    drive(0, 0, 0, 0, 1, 0, 9); tick("dirflag");
    chk("dirflag.flag", int'(bus.rollover_flag), 1);

    // randomized against the reference model
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      drive(r < 3, (r >= 3 && r < 8), $urandom_range(0, 15), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0 ? ~bus.dir : bus.dir,
            $urandom_range(0, 15) == 0 ? ~bus.sat_mode : bus.sat_mode,
            $urandom_range(0, 9) == 0 ? $urandom_range(0, 15) : int'(bus.rollover_val));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
